// File: rtl/debounce_if.sv
// Signal bundle between a debouncer and its user: raw level in, qualified level,
// busy flag and rejected-transition count out.
interface debounce_if;
    logic       din;
    logic       i_glitch_clr;
    logic       o_dout;
    logic       o_busy;
    logic [7:0] o_glitch_cnt;

    modport master (
        output din,
        output i_glitch_clr,
        input  o_dout,
        input  o_busy,
        input  o_glitch_cnt
    );

    modport slave (
        input  din,
        input  i_glitch_clr,
        output o_dout,
        output o_busy,
        output o_glitch_cnt
    );
endinterface

// File: rtl/debounce.sv
// Switch/line debouncer: synchronizer chain feeding a four-state qualifier FSM.
// Define DEBOUNCE_GLITCH_CNT_EN to build the saturating rejected-transition counter.
module debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        LOW_STABLE,
        CHK_HIGH,
        HIGH_STABLE,
        CHK_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TARGET = CNT_WIDTH'(STABLE_CYCLES);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("debounce: SYNC_STAGES must be in 2..4");
    end
    if (CNT_WIDTH < 2 || CNT_WIDTH > 32) begin : g_bad_cnt_width
        $error("debounce: CNT_WIDTH must be in 2..32");
    end
    if (STABLE_CYCLES < 2 ||
        64'(STABLE_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_stable_cycles
        $error("debounce: STABLE_CYCLES must be in 2..(2**CNT_WIDTH-1)");
    end

    // Synchronizer: stage 0 is the only reader of the raw asynchronous input.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= bus.din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    end

    logic                 s_sync;
    state_t               state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 dout_reg;
    logic                 busy_reg;

    assign s_sync   = g_sync[SYNC_STAGES-1].stage_reg;
    assign cnt_next = cnt_reg + CNT_ONE;

    // Qualifier: cnt counts consecutive samples disagreeing with dout_reg; it is
    // cleared on the edge it reaches the target, so it never exceeds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOW_STABLE;
            cnt_reg   <= '0;
            dout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                LOW_STABLE: begin
                    if (s_sync) begin
                        state_reg <= CHK_HIGH;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                HIGH_STABLE: begin
                    if (!s_sync) begin
                        state_reg <= CHK_LOW;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end else begin
                        cnt_reg   <= '0;
                    end
                end
                CHK_HIGH: begin
                    if (s_sync != dout_reg) begin
                        if (cnt_next == CNT_TARGET) begin
                            state_reg <= HIGH_STABLE;
                            cnt_reg   <= '0;
                            dout_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            cnt_reg   <= cnt_next;
                        end
                    end else begin
                        state_reg <= LOW_STABLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                CHK_LOW: begin
                    if (s_sync != dout_reg) begin
                        if (cnt_next == CNT_TARGET) begin
                            state_reg <= LOW_STABLE;
                            cnt_reg   <= '0;
                            dout_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                        end else begin
                            cnt_reg   <= cnt_next;
                        end
                    end else begin
                        state_reg <= HIGH_STABLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= LOW_STABLE;
                    cnt_reg   <= '0;
                    dout_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dout = dout_reg;
    assign bus.o_busy = busy_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_hit;
    logic [7:0] glitch_cnt_reg;

    // A glitch is a qualification abandoned because the sample fell back.
    assign glitch_hit = ((state_reg == CHK_HIGH) || (state_reg == CHK_LOW)) &&
                        (s_sync == dout_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_reg <= 8'd0;
        end else if (bus.i_glitch_clr) begin
            glitch_cnt_reg <= 8'd0;
        end else if (glitch_hit && (glitch_cnt_reg != 8'hFF)) begin
            glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
        end
    end

    assign bus.o_glitch_cnt = glitch_cnt_reg;
`else
    logic unused_glitch_clr;

    assign unused_glitch_clr = bus.i_glitch_clr;
    assign bus.o_glitch_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce (SYNC_STAGES=2, STABLE_CYCLES=4): vector table,
// hand-written corner sequences and random stimulus against a run-length model.
module tb_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic clk;
    logic rst_n;

    debounce_if bus ();

    debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: din seen through a pure delay line, then a run-length rule.
    logic m_hist[$];
    logic m_dout;
    int   m_run;
    int   m_gc;

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_dout = 1'b0;
        m_run  = 0;
        m_gc   = 0;
    endtask

    task automatic model_step(input logic d, input logic c);
        logic s;
        logic glitch;
        m_hist.push_back(d);
        s      = m_hist.pop_front();
        glitch = 1'b0;
        if (s != m_dout) begin
            m_run++;
            if (m_run == STABLE) begin
                m_dout = s;
                m_run  = 0;
            end
        end else begin
            glitch = (m_run > 0);
            m_run  = 0;
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        if (c) m_gc = 0;
        else if (glitch && m_gc < 255) m_gc++;
`else
        if (c || glitch) m_gc = 0;
`endif
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dout"},  32'(bus.o_dout),       32'(m_dout));
        check({tag, "_busy"},  32'(bus.o_busy),       32'(m_run > 0));
        check({tag, "_gcnt"},  32'(bus.o_glitch_cnt), 32'(m_gc));
    endtask

    // Drive inputs just after an edge, take the next edge, sample 1 ns later.
    task automatic step(input logic d, input logic c);
        bus.din          = d;
        bus.i_glitch_clr = c;
        @(posedge clk);
        model_step(d, c);
        #1;
    endtask

    typedef struct {
        logic din;
        logic exp_dout;
        logic exp_busy;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   changes;
        int   rises;
        logic prev_dout;
        int   exp_gc;
        logic lvl;
        int   hold;
        int   cyc;

        // Rise, mirror fall, then a 2-cycle pulse that must be rejected.
        vecs = '{
            '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1},
            '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}
        };

        rst_n            = 1'b0;
        bus.din          = 1'b0;
        bus.i_glitch_clr = 1'b0;
        model_reset();
        #1;
        check("reset_dout", 32'(bus.o_dout), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_gcnt", 32'(bus.o_glitch_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Quiet input: everything stays at rest.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            check("quiet_dout", 32'(bus.o_dout), 32'd0);
            check("quiet_busy", 32'(bus.o_busy), 32'd0);
            check("quiet_gcnt", 32'(bus.o_glitch_cnt), 32'd0);
        end
        $display("quiet phase done");

        changes   = 0;
        rises     = 0;
        prev_dout = bus.o_dout;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].din, 1'b0);
            check($sformatf("vec%0d_dout", i), 32'(bus.o_dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_busy", i), 32'(bus.o_busy), 32'(vecs[i].exp_busy));
            if (bus.o_dout !== prev_dout) begin
                changes++;
                if (bus.o_dout === 1'b1) rises++;
            end
            prev_dout = bus.o_dout;
            $display("vec %0d din=%0b dout=%0b busy=%0b", i, vecs[i].din, bus.o_dout, bus.o_busy);
        end
        check("edge_changes", 32'(changes), 32'd2);
        check("edge_rises", 32'(rises), 32'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        exp_gc = 1;
`else
        exp_gc = 0;
`endif
        check("pulse_gcnt", 32'(bus.o_glitch_cnt), 32'(exp_gc));

        // Asynchronous reset in the middle of a high qualification.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("midchk_busy_before", 32'(bus.o_busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("midchk_busy_rst", 32'(bus.o_busy), 32'd0);
        check("midchk_dout_rst", 32'(bus.o_dout), 32'd0);
        check("midchk_gcnt_rst", 32'(bus.o_glitch_cnt), 32'd0);
        bus.din = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check("postrst_dout", 32'(bus.o_dout), 32'd0);
            check("postrst_busy", 32'(bus.o_busy), 32'd0);
        end
        $display("mid-qualification reset done");

        // 300 rejected pulses must saturate the counter.
        for (int g = 0; g < 300; g++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            check_model("sat");
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        exp_gc = 255;
`else
        exp_gc = 0;
`endif
        check("sat_gcnt", 32'(bus.o_glitch_cnt), 32'(exp_gc));
        check("sat_dout", 32'(bus.o_dout), 32'd0);
        $display("saturation done gcnt=%0d", bus.o_glitch_cnt);

        // Clear on the same edge a glitch is counted: clear wins.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("clrglitch_busy_before", 32'(bus.o_busy), 32'd1);
        step(1'b0, 1'b1);
        check("clrglitch_gcnt", 32'(bus.o_glitch_cnt), 32'd0);
        check("clrglitch_busy", 32'(bus.o_busy), 32'd0);
        step(1'b0, 1'b0);
        $display("clear-vs-glitch done");

        // Toggle every cycle: output frozen, counter bounded.
        for (int i = 0; i < 50; i++) begin
            step(i[0], 1'b0);
            check("toggle_dout", 32'(bus.o_dout), 32'd0);
            check("toggle_cnt_bound", 32'(dut.cnt_reg <= 16'(STABLE)), 32'd1);
            check_model("toggle");
        end
        $display("toggle phase done");

        // Random held levels with occasional counter clears.
        cyc = 0;
        while (cyc < 400) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                step(lvl, ($urandom_range(0, 15) == 0));
                check_model("rand");
                check("rand_cnt_bound", 32'(dut.cnt_reg <= 16'(STABLE)), 32'd1);
                cyc++;
            end
            $display("rand din=%0b hold=%0d dout=%0b gcnt=%0d", lvl, hold, bus.o_dout, bus.o_glitch_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 16, consecutive synchronized samples required before the output changes; legal range 2..(2^CNT_WIDTH-1).
REQ-003 Parameter CNT_WIDTH, default 16, width of the stability counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 din  input  1  raw asynchronous level (switch or bouncing line); no timing relation to clk.
REQ-007 i_glitch_clr  input  1  synchronous clear of o_glitch_cnt, active-high.
REQ-008 o_dout  output  1  debounced, clk-synchronous level; drives din of the downstream edge_detect.
REQ-009 o_busy  output  1  high while a candidate transition is being qualified.
REQ-010 o_glitch_cnt  output  8  count of rejected transitions.

Function
REQ-011 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the sample "s"; no other logic SHALL read din.
REQ-012 The FSM SHALL have four states: LOW_STABLE, CHK_HIGH, HIGH_STABLE, CHK_LOW.
REQ-013 LOW_STABLE with s=1 SHALL go to CHK_HIGH with cnt=1; HIGH_STABLE with s=0 SHALL go to CHK_LOW with cnt=1; otherwise it SHALL hold with cnt=0.
REQ-014 In a CHK state, an s that still differs from o_dout SHALL increment cnt; when the incremented value equals STABLE_CYCLES, o_dout SHALL toggle on that same edge, the FSM SHALL enter the matching STABLE state and cnt SHALL clear.
REQ-015 In a CHK state, an s equal to o_dout SHALL return the FSM to the previous STABLE state, clear cnt, leave o_dout unchanged and count one glitch.
REQ-016 Latency: with din settled before edge 1, o_dout SHALL update on edge SYNC_STAGES+STABLE_CYCLES; a din pulse shorter than STABLE_CYCLES cycles SHALL never reach o_dout.
REQ-017 o_busy SHALL be a registered output, high exactly when the state is CHK_HIGH or CHK_LOW.
REQ-018 o_dout SHALL come directly from a flop with no combinational path from din or s.
REQ-019 cnt SHALL never exceed STABLE_CYCLES; no wrap-around is permitted.
REQ-020 Out-of-range parameter values SHALL cause an elaboration-time error.

Reset
REQ-021 rst_n low SHALL immediately clear the synchronizer, cnt, o_dout=0, o_busy=0 and o_glitch_cnt=0, and force LOW_STABLE, including in the middle of a CHK state.
REQ-022 After reset release with din held high, o_dout SHALL rise through the normal qualification path (REQ-016); it SHALL NOT be preloaded.

Configuration
REQ-023 With macro DEBOUNCE_GLITCH_CNT_EN defined, each REQ-015 event SHALL increment o_glitch_cnt, saturating at 255; i_glitch_clr=1 SHALL set it to 0 on the next edge, and clear SHALL win over a simultaneous glitch.
REQ-024 Without DEBOUNCE_GLITCH_CNT_EN, o_glitch_cnt SHALL be constant 0, i_glitch_clr SHALL be ignored and no counter flops SHALL be inferred; ports remain present.

Verification (SYNC_STAGES=2, STABLE_CYCLES=4, 100 MHz clk)
REQ-025 Reset, then din=0 for 20 cycles -> o_dout=0, o_busy=0, o_glitch_cnt=0 throughout.
REQ-026 din 0->1 settled before edge 1 and held -> o_busy high after edges 3..5, o_dout=1 after edge 6, o_busy=0 after edge 6; the downstream edge_detect emits exactly one pulse; the mirror 1->0 case is also covered.
REQ-027 din high for 2 cycles, then low -> o_dout stays 0, o_busy pulses then returns to 0, o_glitch_cnt=1 (macro on).
REQ-028 rst_n asserted mid-CHK_HIGH, asynchronous to clk -> o_busy=0 and o_dout=0 immediately, with no o_dout rise after release while din=0.
REQ-029 300 glitches -> o_glitch_cnt=255 (saturated); i_glitch_clr together with a glitch -> 0; with macro off -> 0 throughout.
REQ-030 din toggling every cycle for 50 cycles -> o_dout never changes and cnt never exceeds 4 (assertion).
